// File: rtl/crc_lfsr_stream_if.sv
// ============================================================================
// Module      : crc_lfsr_stream_if
// Description : Payload stream and serial CRC handshake bundle for crc_lfsr_stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crc_lfsr_stream_if #(
    parameter int DATA_W = 1
);
    localparam int c_nb_w = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_last;
    logic [c_nb_w-1:0] last_nbits;
    logic              data_ready;
    logic              crc_bit;
    logic              crc_bit_valid;
    logic              crc_bit_ready;

    modport master (
        output data_in, data_valid, data_last, last_nbits, crc_bit_ready,
        input  data_ready, crc_bit, crc_bit_valid
    );

    modport slave (
        input  data_in, data_valid, data_last, last_nbits, crc_bit_ready,
        output data_ready, crc_bit, crc_bit_valid
    );
endinterface

`default_nettype wire

// File: rtl/crc_lfsr_stream.sv
// ============================================================================
// Module      : crc_lfsr_stream
// Description : Galois-LFSR CRC engine, DATA_W bits/beat LSB first, serial
//               MSB-first CRC emit (generate) or zero-residue check.
//               Optional: CRC_LFSR_ERR_CNT_EN adds a saturating err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_lfsr_stream #(
    parameter int               CRC_W          = 24,
    parameter logic [CRC_W-1:0] POLY           = 24'h00065B,
    parameter int               DATA_W         = 1,
    parameter int               INIT_BYTE_SWAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CRC_W-1:0]    init_val,
    input  logic                start,
    input  logic                mode,
    crc_lfsr_stream_if.slave    s_if,
    output logic [CRC_W-1:0]    lfsr,
    output logic                busy,
    output logic                done,
    output logic                crc_ok
`ifdef CRC_LFSR_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    localparam int c_nb_w  = $clog2(DATA_W + 1);
    localparam int c_cnt_w = $clog2(CRC_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CRC_W-1:0]   r_lfsr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mode;
    logic               r_done;
    logic               r_crc_ok;

    logic [CRC_W-1:0]   w_seed;
    logic [CRC_W-1:0]   w_step;
    logic [c_nb_w-1:0]  w_nbits;
    logic               w_beat;
    logic               w_frame_end;
    logic               w_emit_beat;
    logic               w_emit_end;

    if (DATA_W < 1 || DATA_W > 8) begin : g_err_data_w
        $error("crc_lfsr_stream: DATA_W must be within 1..8");
    end

    if (INIT_BYTE_SWAP != 0 && (CRC_W % 8) != 0) begin : g_err_swap
        $error("crc_lfsr_stream: INIT_BYTE_SWAP requires CRC_W to be a multiple of 8");
    end

    if (INIT_BYTE_SWAP != 0) begin : g_swap
        for (genvar b = 0; b < CRC_W / 8; b++) begin : g_byte
            assign w_seed[8*b +: 8] = init_val[CRC_W-8-8*b +: 8];
        end
    end else begin : g_no_swap
        assign w_seed = init_val;
    end

    // Applies the first n single-bit Galois steps of one beat, data bit 0 first.
    function automatic logic [CRC_W-1:0] f_step(
        input logic [CRC_W-1:0]  c,
        input logic [DATA_W-1:0] d,
        input logic [c_nb_w-1:0] n
    );
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(n)) begin
                if (r[CRC_W-1] ^ d[i]) r = (r << 1) ^ POLY;
                else                   r = r << 1;
            end
        end
        return r;
    endfunction

    assign w_nbits = (s_if.data_last && (s_if.last_nbits != '0)) ? s_if.last_nbits
                                                                 : c_nb_w'(DATA_W);
    assign w_step  = f_step(r_lfsr, s_if.data_in, w_nbits);

    // start wins over any beat arriving in the same cycle.
    assign w_beat      = !start && (r_state == S_CALC) && s_if.data_valid;
    assign w_frame_end = w_beat && s_if.data_last;
    assign w_emit_beat = !start && (r_state == S_EMIT) && s_if.crc_bit_ready;
    assign w_emit_end  = w_emit_beat && (r_cnt == c_cnt_w'(CRC_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        s_if.data_ready    = 1'b0;
        s_if.crc_bit_valid = 1'b0;
        busy               = (r_state != S_IDLE);
        case (r_state)
            S_CALC: begin
                s_if.data_ready = 1'b1;
                if (w_frame_end) w_state_nxt = r_mode ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                s_if.crc_bit_valid = 1'b1;
                if (w_emit_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = r_state;
        endcase
        if (start) w_state_nxt = S_CALC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr   <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
            r_crc_ok <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_lfsr   <= w_seed;
                r_mode   <= mode;
                r_crc_ok <= 1'b0;
                r_cnt    <= '0;
            end else if (w_beat) begin
                r_lfsr <= w_step;
                r_cnt  <= '0;
                if (w_frame_end && r_mode) begin
                    r_done   <= 1'b1;
                    r_crc_ok <= (w_step == '0);
                end
            end else if (w_emit_beat) begin
                r_lfsr <= r_lfsr << 1;
                r_cnt  <= r_cnt + c_cnt_w'(1);
                if (w_emit_end) begin
                    r_lfsr <= '0;
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef CRC_LFSR_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_chk_fail;

    assign w_chk_fail = w_frame_end && r_mode && (w_step != '0);

    // Counts together with the failing done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_err_cnt <= '0;
        else if (w_chk_fail && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

    assign lfsr         = r_lfsr;
    assign s_if.crc_bit = r_lfsr[CRC_W-1];
    assign done         = r_done;
    assign crc_ok       = r_crc_ok;

endmodule

`default_nettype wire

// File: tb/tb_crc_lfsr_stream.sv
// ============================================================================
// Module      : tb_crc_lfsr_stream
// Description : Scoreboard bench for crc_lfsr_stream (DATA_W=1 swap / DATA_W=8 no swap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_lfsr_stream;

    typedef struct packed {
        logic        ok;
        logic [23:0] lfsr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] init1, init8;
    logic        start1, start8, mode1, mode8;
    logic [23:0] lfsr1, lfsr8;
    logic        busy1, busy8, done1, done8, ok1, ok8;
`ifdef CRC_LFSR_ERR_CNT_EN
    logic [15:0] err1, err8;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp1_q[$];
    exp_t exp8_q[$];
    logic exp_bit_q[$];
    logic cap_q[$];
    logic fr_q[$];
    exp_t e1, e8;
    logic stall_prev, stall_bit;

    crc_lfsr_stream_if #(.DATA_W(1)) if1 ();
    crc_lfsr_stream_if #(.DATA_W(8)) if8 ();

    crc_lfsr_stream #(
        .CRC_W(24), .POLY(24'h00065B), .DATA_W(1), .INIT_BYTE_SWAP(1)
    ) u_d1 (
        .clk(clk), .rst(rst), .init_val(init1), .start(start1), .mode(mode1),
        .s_if(if1.slave), .lfsr(lfsr1), .busy(busy1), .done(done1), .crc_ok(ok1)
`ifdef CRC_LFSR_ERR_CNT_EN
        , .err_cnt(err1)
`endif
    );

    crc_lfsr_stream #(
        .CRC_W(24), .POLY(24'h00065B), .DATA_W(8), .INIT_BYTE_SWAP(0)
    ) u_d8 (
        .clk(clk), .rst(rst), .init_val(init8), .start(start8), .mode(mode8),
        .s_if(if8.slave), .lfsr(lfsr8), .busy(busy8), .done(done8), .crc_ok(ok8)
`ifdef CRC_LFSR_ERR_CNT_EN
        , .err_cnt(err8)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] m_swap(input logic [23:0] s);
        return {s[7:0], s[15:8], s[23:16]};
    endfunction

    // Bit-serial reference over fr_q.
    function automatic logic [23:0] m_crc_fr(input logic [23:0] seed);
        logic [23:0] c;
        logic        nb;
        c = seed;
        for (int i = 0; i < fr_q.size(); i++) begin
            nb = c[23] ^ fr_q[i];
            c  = {c[22:0], 1'b0} ^ (nb ? 24'h00065B : 24'h000000);
        end
        return c;
    endfunction

    task automatic add_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) fr_q.push_back(v[i]);
    endtask

    task automatic d1_start(input logic [23:0] seed, input logic m);
        @(negedge clk);
        init1  = seed;
        mode1  = m;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic d8_start(input logic [23:0] seed, input logic m);
        @(negedge clk);
        init8  = seed;
        mode8  = m;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic d1_beat(input logic b, input logic last);
        int k;
        k = 0;
        @(negedge clk);
        if1.data_in    = b;
        if1.data_valid = 1'b1;
        if1.data_last  = last;
        while (!if1.data_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check_val("d1_ready_timeout", 32'(k), 0);
        @(posedge clk); #1;
        if1.data_valid = 1'b0;
        if1.data_last  = 1'b0;
    endtask

    task automatic d8_beat(input logic [7:0] v, input logic last, input logic [3:0] nb);
        int k;
        k = 0;
        @(negedge clk);
        if8.data_in    = v;
        if8.data_valid = 1'b1;
        if8.data_last  = last;
        if8.last_nbits = nb;
        while (!if8.data_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check_val("d8_ready_timeout", 32'(k), 0);
        @(posedge clk); #1;
        if8.data_valid = 1'b0;
        if8.data_last  = 1'b0;
        if8.last_nbits = '0;
    endtask

    task automatic d1_send();
        for (int i = 0; i < fr_q.size(); i++) d1_beat(fr_q[i], i == fr_q.size() - 1);
    endtask

    task automatic push_bits(input logic [23:0] c);
        for (int i = 23; i >= 0; i--) exp_bit_q.push_back(c[i]);
    endtask

    task automatic d1_emit_all();
        int k;
        k = 0;
        while (busy1 && k < 400) begin
            if1.crc_bit_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        if1.crc_bit_ready = 1'b0;
        check_val("d1_emit_finished", {31'b0, busy1}, 0);
        @(negedge clk); #1;
    endtask

    task automatic d1_emit_n(input int n);
        if1.crc_bit_ready = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        if1.crc_bit_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp1_q.delete();
        exp8_q.delete();
        exp_bit_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done1) begin
                check_val("d1_done_expected", {31'b0, exp1_q.size() > 0}, 1);
                if (exp1_q.size() > 0) begin
                    e1 = exp1_q.pop_front();
                    check_val("d1_crc_ok", {31'b0, ok1}, {31'b0, e1.ok});
                    check_val("d1_lfsr_at_done", {8'b0, lfsr1}, {8'b0, e1.lfsr});
                end
            end
            if (if1.crc_bit_valid && stall_prev)
                check_val("d1_stall_hold", {31'b0, if1.crc_bit}, {31'b0, stall_bit});
            stall_prev = if1.crc_bit_valid && !if1.crc_bit_ready;
            stall_bit  = if1.crc_bit;
            if (if1.crc_bit_valid && if1.crc_bit_ready) begin
                cap_q.push_back(if1.crc_bit);
                check_val("d1_bit_expected", {31'b0, exp_bit_q.size() > 0}, 1);
                if (exp_bit_q.size() > 0)
                    check_val("d1_crc_bit", {31'b0, if1.crc_bit}, {31'b0, exp_bit_q.pop_front()});
            end
            if (done8) begin
                check_val("d8_done_expected", {31'b0, exp8_q.size() > 0}, 1);
                if (exp8_q.size() > 0) begin
                    e8 = exp8_q.pop_front();
                    check_val("d8_crc_ok", {31'b0, ok8}, {31'b0, e8.ok});
                    check_val("d8_lfsr_at_done", {8'b0, lfsr8}, {8'b0, e8.lfsr});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] m;

        rst = 1'b1;
        init1 = '0; init8 = '0; start1 = 1'b0; start8 = 1'b0; mode1 = 1'b0; mode8 = 1'b0;
        if1.data_in = '0; if1.data_valid = 1'b0; if1.data_last = 1'b0;
        if1.last_nbits = '0; if1.crc_bit_ready = 1'b0;
        if8.data_in = '0; if8.data_valid = 1'b0; if8.data_last = 1'b0;
        if8.last_nbits = '0; if8.crc_bit_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_lfsr", {8'b0, lfsr1}, 0);
        check_val("rst_busy", {31'b0, busy1}, 0);
        check_val("rst_done", {31'b0, done1}, 0);
        check_val("rst_crc_ok", {31'b0, ok1}, 0);
        check_val("rst_data_ready", {31'b0, if1.data_ready}, 0);
        check_val("rst_bit_valid", {31'b0, if1.crc_bit_valid}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero seed, one '1' bit: result is POLY.
        d1_start(24'h000000, 1'b1);
        exp1_q.push_back('{ok: 1'b0, lfsr: 24'h00065B});
        d1_beat(1'b1, 1'b1);
        @(negedge clk); #1;
        check_val("seed_done_seen", 32'(exp1_q.size()), 0);

        d1_start(24'h123456, 1'b0);
        check_val("seed_swap", {8'b0, lfsr1}, 32'h00563412);
        d8_start(24'h123456, 1'b1);
        check_val("seed_no_swap", {8'b0, lfsr8}, 32'h00123456);

        pulse_rst();

        // Generate, then check with the captured CRC appended.
        fr_q.delete();
        add_bits(8'hA5, 8);
        m = m_crc_fr(m_swap(24'h555555));
        cap_q.delete();
        d1_start(24'h555555, 1'b0);
        exp1_q.push_back('{ok: 1'b0, lfsr: 24'h000000});
        push_bits(m);
        d1_send();
        d1_emit_all();
        check_val("gen_done_seen", 32'(exp1_q.size()), 0);
        check_val("gen_bits_left", 32'(exp_bit_q.size()), 0);
        check_val("gen_cap_len", 32'(cap_q.size()), 24);

        foreach (cap_q[i]) fr_q.push_back(cap_q[i]);
        d1_start(24'h555555, 1'b1);
        exp1_q.push_back('{ok: 1'b1, lfsr: 24'h000000});
        d1_send();
        @(negedge clk); #1;
        check_val("chk_good_seen", 32'(exp1_q.size()), 0);

        fr_q[12] = ~fr_q[12];
        d1_start(24'h555555, 1'b1);
        exp1_q.push_back('{ok: 1'b0, lfsr: m_crc_fr(m_swap(24'h555555))});
        d1_send();
        @(negedge clk); #1;
        check_val("chk_bad_seen", 32'(exp1_q.size()), 0);
`ifdef CRC_LFSR_ERR_CNT_EN
        check_val("err_cnt_one", {16'b0, err1}, 1);
`endif

        // Width equivalence: two full bytes, then a 3-bit final beat.
        fr_q.delete();
        add_bits(8'hA5, 8);
        add_bits(8'h3C, 8);
        m = m_crc_fr(m_swap(24'hABCDEF));
        d1_start(24'hABCDEF, 1'b1);
        exp1_q.push_back('{ok: (m == 24'h0), lfsr: m});
        d1_send();
        m = m_crc_fr(24'hABCDEF);
        d8_start(24'hABCDEF, 1'b1);
        exp8_q.push_back('{ok: (m == 24'h0), lfsr: m});
        d8_beat(8'hA5, 1'b0, 4'd0);
        d8_beat(8'h3C, 1'b1, 4'd0);
        @(negedge clk); #1;
        check_val("w16_seen", 32'(exp1_q.size() + exp8_q.size()), 0);

        fr_q.delete();
        add_bits(8'hA5, 8);
        add_bits(8'hFF, 3);
        m = m_crc_fr(24'h13579B);
        d8_start(24'h13579B, 1'b1);
        exp8_q.push_back('{ok: (m == 24'h0), lfsr: m});
        d8_beat(8'hA5, 1'b0, 4'd0);
        d8_beat(8'hFF, 1'b1, 4'd3);
        @(negedge clk); #1;
        check_val("nbits_seen", 32'(exp8_q.size()), 0);

        // Abort mid-CALC: reload, no done.
        d1_start(24'h0F0F0F, 1'b0);
        d1_beat(1'b1, 1'b0);
        d1_beat(1'b0, 1'b0);
        d1_beat(1'b1, 1'b0);
        d1_start(24'h0A0B0C, 1'b0);
        check_val("abort_calc_lfsr", {8'b0, lfsr1}, 32'h000C0B0A);

        // Abort mid-EMIT, then a full frame from the new seed.
        fr_q.delete();
        add_bits(8'hA5, 8);
        push_bits(m_crc_fr(24'h0C0B0A));
        d1_send();
        d1_emit_n(5);
        exp_bit_q.delete();
        d1_start(24'h112233, 1'b0);
        check_val("abort_emit_lfsr", {8'b0, lfsr1}, 32'h00332211);
        check_val("abort_emit_busy", {31'b0, busy1}, 1);
        exp1_q.push_back('{ok: 1'b0, lfsr: 24'h000000});
        push_bits(m_crc_fr(24'h332211));
        d1_send();
        d1_emit_all();
        check_val("restart_done_seen", 32'(exp1_q.size()), 0);
        check_val("restart_bits_left", 32'(exp_bit_q.size()), 0);

        // Asynchronous reset in the middle of EMIT.
        d1_start(24'h445566, 1'b0);
        push_bits(m_crc_fr(24'h665544));
        d1_send();
        d1_emit_n(3);
        exp_bit_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", {31'b0, busy1}, 0);
        check_val("arst_bit_valid", {31'b0, if1.crc_bit_valid}, 0);
        check_val("arst_lfsr", {8'b0, lfsr1}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("arst_no_done", {31'b0, done1}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crc_lfsr_stream.md
Name: crc_lfsr_stream

Overview:
- Parametrised Galois-LFSR CRC engine for the BLE link layer and future PHY variants.
- Processes DATA_W bits per cycle, LSB of each word first, with a valid/ready stream interface.
- Generate mode: after the last data word, serialises the CRC out MSB-first.
- Check mode: the received CRC is fed through after the payload and a zero residue is flagged; sits between the whitening/dewhitening stage and the packet FSM.

Parameters:
- CRC_W, 24: CRC register width.
- POLY, 24'h00065B: feedback taps, x^CRC_W implicit; the BLE default encodes x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- DATA_W, 1: input bits per beat, 1..8.
- INIT_BYTE_SWAP, 1: 1 = reverse byte order of init_val on load (CRC_W multiple of 8); 0 = load as-is.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- init_val  in  CRC_W  LFSR seed, sampled on start.
- start  in  1  one-cycle pulse: load seed, latch mode, enter CALC.
- mode  in  1  0 = generate, 1 = check; sampled on start.
- data_in  in  DATA_W  payload bits; data_in[0] processed first.
- data_valid  in  1  beat valid.
- data_last  in  1  final beat of the frame.
- last_nbits  in  $clog2(DATA_W+1)  valid bits in the last beat; 0 means DATA_W.
- data_ready  out  1  high only in CALC.
- crc_bit  out  1  serial CRC output, generate mode.
- crc_bit_valid  out  1  high only in EMIT.
- crc_bit_ready  in  1  downstream accept.
- lfsr  out  CRC_W  live CRC register.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of frame.
- crc_ok  out  1  check result; held until next start.

Behaviour:
- Reset: lfsr=0, state IDLE, all outputs 0.
- States: IDLE, CALC, EMIT.
- start in any state, including mid-frame:
  - lfsr <= init_val, byte-swapped if INIT_BYTE_SWAP; crc_ok <= 0; state <= CALC.
  - start has priority over a coincident data or emit beat; that beat is dropped.
- Per-bit step: nb = lfsr[CRC_W-1] ^ d; lfsr <= (lfsr<<1) ^ (nb ? POLY : 0).
  - One beat applies DATA_W steps combinationally in one cycle, in the order d = data_in[0], data_in[1], ...
  - On a data_last beat only last_nbits steps apply.
- Beat acceptance: accepted when data_valid && data_ready; lfsr updates on the following edge (latency 1). data_valid outside CALC is ignored.
- CALC exit on an accepted last beat:
  - mode=0: next state EMIT.
  - mode=1: next state IDLE; done=1 and crc_ok=(updated lfsr==0) in the same cycle.
- EMIT:
  - crc_bit = lfsr[CRC_W-1].
  - Each crc_bit_valid && crc_bit_ready shifts lfsr left by 1, zero fill, with no feedback.
  - An internal counter counts CRC_W accepted bits.
  - On the CRC_W-th accept: next state IDLE, done pulses in the following cycle, lfsr=0.
  - Stalls on crc_bit_ready=0 hold crc_bit stable.
- lfsr output is the pre-emit CRC while in CALC; after EMIT it is not meaningful.
- rst mid-frame aborts immediately to the reset values; no done pulse.
- DATA_W outside 1..8 or CRC_W not a multiple of 8 with INIT_BYTE_SWAP=1: elaboration-time $error.

Optional Feature:
- Macro CRC_LFSR_ERR_CNT_EN.
- When defined: adds output err_cnt [15:0], reset 0.
  - Increments, saturating at 16'hFFFF, in the cycle done pulses with mode=1 and crc_ok=0.
  - Cleared only by rst; start does not clear it.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Seed: DATA_W=1, init_val=0, start, single beat data_in=1 with data_last → done=1, crc_ok=0, lfsr=24'h00065B.
- Byte swap: init_val=24'h123456, INIT_BYTE_SWAP=1, start → lfsr=24'h563412 next cycle; with INIT_BYTE_SWAP=0 → 24'h123456.
- Generate then check: mode=0, seed 24'h555555, payload 8'hA5 in 8 single-bit beats, capture 24 emitted bits with random crc_bit_ready stalls; rerun mode=1 with payload then captured bits → crc_ok=1. Flip any one bit → crc_ok=0, and err_cnt=1 with the macro.
- Width equivalence: DATA_W=8 with bytes 8'hA5, 8'h3C vs DATA_W=1 with the same 16 bits LSB-first → identical lfsr. last_nbits=3 on a final beat 8'hFF equals 3 one-bit beats of 1.
- Abort: start asserted mid-CALC and again mid-EMIT → lfsr reloads, no done, frame restarts. rst during EMIT → busy=0, crc_bit_valid=0, lfsr=0 immediately.
